// File: rtl/dmem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter_pkg
// Shared constants and types for the data-memory port arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default word-address and data widths (64 x 32)
//   PORT_CORE / PORT_EXT    : port numbers (core load/store, external loader)
//   lock_owner_e            : which port currently holds the atomic lock
//   lock_of()               : maps a port number to its lock-owner code
// -----------------------------------------------------------------------------
package dmem_port_arbiter_pkg;

   localparam int ADDR_W_DEF = 6;
   localparam int DATA_W_DEF = 32;

   localparam logic PORT_CORE = 1'b0;
   localparam logic PORT_EXT  = 1'b1;

   typedef enum logic [1:0] {
      LOCK_NONE = 2'b00,
      LOCK_P0   = 2'b01,
      LOCK_P1   = 2'b10
   } lock_owner_e;

   function automatic lock_owner_e lock_of(input logic port);
      return (port == PORT_EXT) ? LOCK_P1 : LOCK_P0;
   endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter_if
// One requester's view of the shared data memory.
//   req    : access request, held with we/addr/wdata until gnt
//   we     : 1 = write, 0 = read
//   addr   : word address
//   wdata  : write data
//   lock   : keep ownership after the grant (atomic read-modify-write)
//   gnt    : access issued this cycle
//   rvalid : read data valid (one cycle after a read grant)
//   rdata  : read data, held after rvalid
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface dmem_port_arbiter_if
   import dmem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) ();

   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              lock;
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;

   modport master (
      output req, we, addr, wdata, lock,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, wdata, lock,
      output gnt, rvalid, rdata
   );

endinterface

// File: rtl/dmem_port_arbiter_rr_grant2.sv
// -----------------------------------------------------------------------------
// rr_grant2
// Combinational two-way round-robin grant with a lock mask.
//   req[1:0]   : requests from port 0 / port 1
//   prio       : port favoured when both request
//   lock_owner : port holding the lock; the other port is masked off
//   gnt[1:0]   : one-hot or zero grant
// -----------------------------------------------------------------------------
module rr_grant2
   import dmem_port_arbiter_pkg::*;
(
   input  logic [1:0]  req,
   input  logic        prio,
   input  lock_owner_e lock_owner,
   output logic [1:0]  gnt
);

   always_comb begin
      gnt = 2'b00;
      case (lock_owner)
         LOCK_P0: gnt[0] = req[0];
         LOCK_P1: gnt[1] = req[1];
         default: begin
            // Unused encoding 2'b11 falls through here and behaves as unlocked.
            case (req)
               2'b01:   gnt = 2'b01;
               2'b10:   gnt = 2'b10;
               2'b11:   gnt = (prio == PORT_EXT) ? 2'b10 : 2'b01;
               default: gnt = 2'b00;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
// Shares a single-port, word-addressed data memory between the core
// load/store path (port 0) and the external loader/debug port (port 1).
// Round-robin arbitration with an optional atomic lock; one access issued
// per cycle; read data returns one cycle after issue to the issuing port.
//   clk        : system clock
//   reset      : synchronous, active-low reset
//   p0, p1     : requester ports (see dmem_port_arbiter_if)
//   mem_en     : memory access strobe
//   mem_we     : memory write strobe
//   mem_addr   : memory word address
//   mem_wdata  : memory write data
//   mem_rdata  : memory read data, valid the cycle after a read strobe
//   stall0     : port 0 requesting but not granted; core freezes on this
// -----------------------------------------------------------------------------
module dmem_port_arbiter
   import dmem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                clk,
   input  logic                reset,
   dmem_port_arbiter_if.slave  p0,
   dmem_port_arbiter_if.slave  p1,
   output logic                mem_en,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                stall0
);

   // Gather both ports into indexable form.
   logic [1:0]        req_v;
   logic [1:0]        we_v;
   logic [1:0]        lock_v;
   logic [1:0]        gnt_v;
   logic [ADDR_W-1:0] addr_v  [2];
   logic [DATA_W-1:0] wdata_v [2];
   logic [1:0]        rvalid_v;
   logic [DATA_W-1:0] rdata_v [2];

   assign req_v      = {p1.req,  p0.req};
   assign we_v       = {p1.we,   p0.we};
   assign lock_v     = {p1.lock, p0.lock};
   assign addr_v[0]  = p0.addr;
   assign addr_v[1]  = p1.addr;
   assign wdata_v[0] = p0.wdata;
   assign wdata_v[1] = p1.wdata;

   // State
   logic        prio_reg;
   lock_owner_e lock_owner_reg;
   lock_owner_e lock_owner_next;
   logic        rd_pend_reg;
   logic        rd_port_reg;

   rr_grant2 u_grant (
      .req        (req_v),
      .prio       (prio_reg),
      .lock_owner (lock_owner_reg),
      .gnt        (gnt_v)
   );

   // Grant is one-hot, so bit 1 alone identifies the winner whenever mem_en is set.
   logic gnt_port;
   assign gnt_port = gnt_v[1];

   // Issue: mux the winning port onto the memory bus, all zero when idle.
   always_comb begin
      mem_en    = |gnt_v;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (mem_en) begin
         mem_we    = we_v[gnt_port];
         mem_addr  = addr_v[gnt_port];
         mem_wdata = wdata_v[gnt_port];
      end
   end

   assign stall0 = p0.req & ~gnt_v[0];

   // Lock ownership: only taken at a grant, released the first cycle the
   // owner lowers its lock, and never stolen by the other port.
   always_comb begin
      lock_owner_next = lock_owner_reg;
      case (lock_owner_reg)
         LOCK_P0: begin
            if (!lock_v[0]) lock_owner_next = LOCK_NONE;
         end
         LOCK_P1: begin
            if (!lock_v[1]) lock_owner_next = LOCK_NONE;
         end
         LOCK_NONE: begin
            if (mem_en && lock_v[gnt_port]) lock_owner_next = lock_of(gnt_port);
         end
         default: lock_owner_next = LOCK_NONE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         prio_reg       <= PORT_CORE;
         lock_owner_reg <= LOCK_NONE;
         rd_pend_reg    <= 1'b0;
         rd_port_reg    <= PORT_CORE;
      end else begin
         lock_owner_reg <= lock_owner_next;
         rd_pend_reg    <= mem_en & ~mem_we;
         if (mem_en) begin
            // The port that just lost the slot is favoured next time.
            prio_reg    <= ~gnt_port;
            rd_port_reg <= gnt_port;
         end
      end
   end

   // Read return: rvalid is a single-cycle pulse to the issuing port; rdata
   // passes mem_rdata through in that cycle and holds the captured word after.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_port
         logic [DATA_W-1:0] rdata_reg;

         assign rvalid_v[gi] = rd_pend_reg && (rd_port_reg == 1'(gi));

         always_ff @(posedge clk) begin
            if (!reset) begin
               rdata_reg <= '0;
            end else if (rvalid_v[gi]) begin
               rdata_reg <= mem_rdata;
            end
         end

         assign rdata_v[gi] = rvalid_v[gi] ? mem_rdata : rdata_reg;
      end
   endgenerate

   assign p0.gnt    = gnt_v[0];
   assign p1.gnt    = gnt_v[1];
   assign p0.rvalid = rvalid_v[0];
   assign p1.rvalid = rvalid_v[1];
   assign p0.rdata  = rdata_v[0];
   assign p1.rdata  = rdata_v[1];

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;
   import dmem_port_arbiter_pkg::*;

   localparam int AW = 6;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p0_if ();
   dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p1_if ();

   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic          stall0;

   dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .p0        (p0_if),
      .p1        (p1_if),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .stall0    (stall0)
   );

   // Synchronous single-port memory model driven by the arbiter.
   logic [DW-1:0] mem     [64];
   logic [DW-1:0] exp_mem [64];

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   typedef struct {
      logic          port;
      logic [DW-1:0] data;
   } ret_t;

   ret_t          sb[$];
   int            vectors = 0;
   int            miscompares = 0;
   logic [DW-1:0] exp_rdata0 = '0;
   logic [DW-1:0] exp_rdata1 = '0;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
      end
   endtask

   task automatic set0(input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic l);
      p0_if.req = r; p0_if.we = w; p0_if.addr = a; p0_if.wdata = d; p0_if.lock = l;
   endtask

   task automatic set1(input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic l);
      p1_if.req = r; p1_if.we = w; p1_if.addr = a; p1_if.wdata = d; p1_if.lock = l;
   endtask

   // One clock cycle: check outputs at the falling edge against the expected
   // grant (e0/e1) and the scoreboard, then advance past the rising edge.
   task automatic step(input logic e0, input logic e1, input string tag);
      ret_t          it;
      logic          ev0;
      logic          ev1;
      logic          ew;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      @(negedge clk);
      ev0 = 1'b0;
      ev1 = 1'b0;
      if (sb.size() > 0) begin
         it = sb.pop_front();
         if (it.port) begin ev1 = 1'b1; exp_rdata1 = it.data; end
         else         begin ev0 = 1'b1; exp_rdata0 = it.data; end
      end
      chk({tag, "_rvalid0"}, DW'(p0_if.rvalid), DW'(ev0));
      chk({tag, "_rvalid1"}, DW'(p1_if.rvalid), DW'(ev1));
      chk({tag, "_rdata0"},  p0_if.rdata, exp_rdata0);
      chk({tag, "_rdata1"},  p1_if.rdata, exp_rdata1);
      chk({tag, "_gnt0"},    DW'(p0_if.gnt), DW'(e0));
      chk({tag, "_gnt1"},    DW'(p1_if.gnt), DW'(e1));
      chk({tag, "_stall0"},  DW'(stall0), DW'(p0_if.req & ~e0));
      ew = 1'b0; ea = '0; ed = '0;
      if (e0)      begin ew = p0_if.we; ea = p0_if.addr; ed = p0_if.wdata; end
      else if (e1) begin ew = p1_if.we; ea = p1_if.addr; ed = p1_if.wdata; end
      chk({tag, "_mem_en"},    DW'(mem_en), DW'(e0 | e1));
      chk({tag, "_mem_we"},    DW'(mem_we), DW'(ew));
      chk({tag, "_mem_addr"},  DW'(mem_addr), DW'(ea));
      chk({tag, "_mem_wdata"}, mem_wdata, ed);
      if (e0 | e1) begin
         if (ew) exp_mem[ea] = ed;
         else begin
            it.port = e1;
            it.data = exp_mem[ea];
            sb.push_back(it);
         end
      end
      if (!reset) begin
         sb.delete();
         exp_rdata0 = '0;
         exp_rdata1 = '0;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         mem[i]     = 32'hA500_0000 | (i * 32'h0001_0203);
         exp_mem[i] = 32'hA500_0000 | (i * 32'h0001_0203);
      end
      mem[0]     = 32'h1234_5678;
      exp_mem[0] = 32'h1234_5678;
      set0(0, 0, '0, '0, 0);
      set1(0, 0, '0, '0, 0);

      // 1: reset, then a single port-0 read
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      step(0, 0, "t1_idle");
      set0(1, 0, 6'd0, '0, 0);
      step(1, 0, "t1_rd");
      set0(0, 0, '0, '0, 0);
      step(0, 0, "t1_ret");

      // 2: both ports reading continuously after reset alternate 0,1,0,1
      reset = 1'b0;
      step(0, 0, "t2_rst");
      reset = 1'b1;
      set0(1, 0, 6'd1, '0, 0);
      set1(1, 0, 6'd63, '0, 0);
      step(1, 0, "t2_a");
      step(0, 1, "t2_b");
      step(1, 0, "t2_c");
      step(0, 1, "t2_d");
      set0(0, 0, '0, '0, 0);
      set1(0, 0, '0, '0, 0);
      step(0, 0, "t2_ret");

      // 3: port 1 writes, port 0 reads it back
      set1(1, 1, 6'd5, 32'hDEAD_BEEF, 0);
      step(0, 1, "t3_wr");
      set1(0, 0, '0, '0, 0);
      set0(1, 0, 6'd5, '0, 0);
      step(1, 0, "t3_rd");
      set0(0, 0, '0, '0, 0);
      step(0, 0, "t3_ret");

      // 4: port 1 locks for three grants while port 0 waits
      set0(1, 0, 6'd8, '0, 0);
      set1(1, 0, 6'd7, '0, 1);
      step(0, 1, "t4_lk1");
      step(0, 1, "t4_lk2");
      step(0, 1, "t4_lk3");
      set1(0, 0, 6'd7, '0, 0);
      step(0, 0, "t4_unlk");
      step(1, 0, "t4_p0");
      set0(0, 0, '0, '0, 0);
      step(0, 0, "t4_ret");

      // 5a: reset right after a locked read drops the return and the lock
      set0(1, 0, 6'd9, '0, 1);
      reset = 1'b0;
      step(1, 0, "t5_rd_rst");
      reset = 1'b1;
      set0(0, 0, '0, '0, 0);
      step(0, 0, "t5_drop");
      set1(1, 0, 6'd10, '0, 0);
      step(0, 1, "t5_lk_clr");
      set1(0, 0, '0, '0, 0);
      step(0, 0, "t5_ret");
      // 5b: reset returns priority to port 0
      set0(1, 1, 6'd3, 32'h0BAD_F00D, 0);
      reset = 1'b0;
      step(1, 0, "t5_wr_rst");
      reset = 1'b1;
      set0(1, 0, 6'd3, '0, 0);
      set1(1, 0, 6'd4, '0, 0);
      step(1, 0, "t5_prio_clr");
      set0(0, 0, '0, '0, 0);
      set1(0, 0, '0, '0, 0);
      step(0, 0, "t5_ret2");

      // 6: port 1 request raised and dropped while port 0 holds the lock
      set0(1, 0, 6'd11, '0, 1);
      step(1, 0, "t6_lk0");
      set0(0, 0, 6'd11, '0, 1);
      set1(1, 0, 6'd12, '0, 0);
      step(0, 0, "t6_held1");
      step(0, 0, "t6_held2");
      set1(0, 0, '0, '0, 0);
      step(0, 0, "t6_drop");
      set0(0, 0, '0, '0, 0);
      step(0, 0, "t6_unlk");
      set1(1, 0, 6'd12, '0, 0);
      step(0, 1, "t6_p1");
      set1(0, 0, '0, '0, 0);
      step(0, 0, "t6_ret");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port word-addressed data memory between two requesters.
  - Port 0: the core load/store path.
  - Port 1: the external loader/debug port, which preloads data and dumps results.
- Round-robin arbitration. Optional lock lets the current owner do an atomic read-modify-write.
- One access is issued per cycle. Read data returns one cycle after issue, routed to the issuing port.
- Sits between the core's memory-stage signals and the data memory array.

Parameters:
ADDR_W, 6, word address width (64 words)
DATA_W, 32, data word width

Ports:
clk  in  1  system clock; all state changes on rising edge
reset  in  1  synchronous, active-low reset (asserted when 0)
req0  in  1  port 0 access request; held until gnt0
we0  in  1  port 0 write enable (1=write, 0=read)
addr0  in  ADDR_W  port 0 word address
wdata0  in  DATA_W  port 0 write data
lock0  in  1  port 0 keeps ownership after its grant
gnt0  out  1  port 0 access issued this cycle
rvalid0  out  1  port 0 read data valid
rdata0  out  DATA_W  port 0 read data
req1, we1, addr1, wdata1, lock1, gnt1, rvalid1, rdata1: same as port 0, for port 1
mem_en  out  1  memory access strobe
mem_we  out  1  memory write strobe
mem_addr  out  ADDR_W  memory word address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid the cycle after a read strobe
stall0  out  1  req0 & ~gnt0; the core freezes PC and pipeline on this

Behaviour:
- Reset is checked in clocked logic only. Reset state:
  - prio=0 (port 0 favoured), lock_owner=NONE, rd_pend=0.
  - All gnt, rvalid and mem_* outputs are 0; rdata0 and rdata1 are 0.
- Grant is combinational in the cycle of request, from req0, req1, prio and lock_owner:
  - lock_owner=P: only port P may be granted. The other port's request is held off (its gnt=0).
  - Otherwise, with a single request: grant it.
  - Otherwise, with both requesting: grant port prio.
  - At most one gnt per cycle (one-hot or zero).
- Issue:
  - gnt asserted means mem_en=1, with mem_we, mem_addr and mem_wdata muxed from the granted port the same cycle.
  - No grant means mem_en=0 and mem_we=0, with address and data driven 0.
- Priority update on each grant to port P: prio <= ~P (the loser is favoured next).
- Lock:
  - A granted port P with lockP=1 sets lock_owner=P.
  - lock_owner returns to NONE on the first cycle the owner has lockP=0.
  - Lock is ignored unless it arrives with or after a grant. It cannot pre-empt the current owner.
- Read return:
  - A granted read sets rd_pend=1 and rd_port=P.
  - Next cycle: rvalidP=1 and rdataP=mem_rdata, for exactly one cycle.
  - rdataP holds its last value afterwards.
- Back-to-back reads are allowed every cycle, because the return pipeline is a single register stage.
- Writes produce no rvalid. Write completes at the grant edge.
- Simultaneous events:
  - A read return to port X and a new grant to port Y can occur in the same cycle. They are independent.
- Reset mid-operation:
  - A pending read is dropped, so no rvalid follows reset.
  - Lock is cleared.
- Request protocol:
  - A requester must hold req, we, addr and wdata stable until gnt.
  - Dropping req before gnt is legal and issues nothing.
- Addresses wrap naturally within ADDR_W. There is no range checking.

Decomposition:
- Shared package constants:
  - PORT_CORE=0, PORT_EXT=1.
  - Lock-owner encoding NONE/P0/P1 (2-bit).
  - ADDR_W and DATA_W defaults, matching the data memory depth.
- One natural sub-module: rr_grant2.
  - Combinational two-way round-robin grant with a lock mask.
  - Inputs: req[1:0], prio, lock_owner. Output: gnt[1:0].
- Top level holds prio, lock_owner, rd_pend/rd_port and the rdata registers.

Test Plan:
1. Reset low for 2 cycles, then high → all gnt, rvalid and mem_en are 0, and rdata0/rdata1 are 0. First req0=1 read of addr 0 with mem_rdata=0x12345678 → gnt0 the same cycle; next cycle rvalid0=1, rdata0=0x12345678.
2. req0 and req1 held continuously, both reads, after reset → grants alternate 0,1,0,1. Each rvalid lands on the correct port one cycle after its grant. stall0 is high on port-1 cycles.
3. Port 1 writes 0xDEADBEEF to addr 5, then port 0 reads addr 5 → mem_we=1, mem_addr=5 on the write cycle. Port 0 read is granted next (prio=0), and rdata0 equals the memory model's 0xDEADBEEF.
4. Port 1 holds lock1=1 for 3 grants while req0=1 is continuous → gnt0=0 and stall0=1 for those cycles. Port 0 is granted the first cycle after lock1 drops.
5. Port 0 read granted, then reset=0 on the next edge → no rvalid0 afterwards, rdata0=0, lock and prio cleared.
6. req1 raised, then dropped before grant while port 0 holds lock0 → no mem access for port 1 and gnt1 is never asserted.
